// File: rtl/probe_level_ctrl.sv
// Logic-probe threshold sequencer: drives both DACs, waits for settling,
// then classifies comparator samples over a window and reports counts.
module probe_level_ctrl #(
  parameter int COUNT_BITS    = 20,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic [4:0]            cfg_hi_code,
  input  logic [4:0]            cfg_lo_code,
  input  logic [COUNT_BITS-1:0] cfg_window,
  input  logic                  cfg_continuous,
  input  logic                  cfg_write,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  comp_out_hi,
  input  logic                  comp_out_lo,
  output logic [4:0]            dac1_code,
  output logic [4:0]            dac2_code,
  output logic                  busy,
  output logic                  result_valid,
  output logic [COUNT_BITS-1:0] cnt_high,
  output logic [COUNT_BITS-1:0] cnt_low,
  output logic [COUNT_BITS-1:0] cnt_z,
  output logic [COUNT_BITS-1:0] cnt_rise
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    LV_NONE,
    LV_LOW,
    LV_HIGH
  } lvl_t;

  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES - 1);

  function automatic logic [COUNT_BITS-1:0] sat_inc(
    input logic [COUNT_BITS-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t                r_state;
  lvl_t                  r_last;
  logic                  r_hi_m;
  logic                  r_hi_s;
  logic                  r_lo_m;
  logic                  r_lo_s;
  logic [4:0]            r_sh_hi;
  logic [4:0]            r_sh_lo;
  logic [COUNT_BITS-1:0] r_sh_win;
  logic                  r_sh_cont;
  logic [7:0]            r_settle;
  logic [COUNT_BITS-1:0] r_win;
  logic [COUNT_BITS-1:0] r_w_hi;
  logic [COUNT_BITS-1:0] r_w_lo;
  logic [COUNT_BITS-1:0] r_w_z;
  logic [COUNT_BITS-1:0] r_w_rise;
  logic                  r_stop;

  logic [4:0]            w_sh_hi;
  logic [4:0]            w_sh_lo;
  logic [COUNT_BITS-1:0] w_sh_win;
  logic                  w_sh_cont;
  logic                  w_is_hi;
  logic                  w_is_lo;
  logic                  w_is_z;
  logic                  w_rise;
  logic [COUNT_BITS-1:0] w_n_hi;
  logic [COUNT_BITS-1:0] w_n_lo;
  logic [COUNT_BITS-1:0] w_n_z;
  logic [COUNT_BITS-1:0] w_n_rise;
  lvl_t                  w_n_last;
  logic                  w_enter;

  // Shadow view including a write in this same cycle
  assign w_sh_hi   = cfg_write ? cfg_hi_code : r_sh_hi;
  assign w_sh_lo   = cfg_write ? cfg_lo_code : r_sh_lo;
  assign w_sh_cont = cfg_write ? cfg_continuous : r_sh_cont;
  assign w_sh_win  = !cfg_write ? r_sh_win :
                     (cfg_window == '0) ? COUNT_BITS'(1) : cfg_window;

  assign w_is_hi = r_hi_s;
  assign w_is_lo = ~r_hi_s & r_lo_s;
  assign w_is_z  = ~r_hi_s & ~r_lo_s;
  assign w_rise  = w_is_hi & (r_last == LV_LOW);

  assign w_n_hi   = w_is_hi ? sat_inc(r_w_hi) : r_w_hi;
  assign w_n_lo   = w_is_lo ? sat_inc(r_w_lo) : r_w_lo;
  assign w_n_z    = w_is_z ? sat_inc(r_w_z) : r_w_z;
  assign w_n_rise = w_rise ? sat_inc(r_w_rise) : r_w_rise;
  assign w_n_last = w_is_hi ? LV_HIGH :
                    w_is_lo ? LV_LOW : r_last;

  assign w_enter =
    ((r_state == ST_IDLE) & start) |
    ((r_state == ST_DONE) & w_sh_cont & ~(r_stop | stop));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_hi_m <= 1'b0;
      r_hi_s <= 1'b0;
      r_lo_m <= 1'b0;
      r_lo_s <= 1'b0;
    end else begin
      r_hi_m <= comp_out_hi;
      r_hi_s <= r_hi_m;
      r_lo_m <= comp_out_lo;
      r_lo_s <= r_lo_m;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_sh_hi   <= '0;
      r_sh_lo   <= '0;
      r_sh_win  <= COUNT_BITS'(1);
      r_sh_cont <= 1'b0;
    end else begin
      r_sh_hi   <= w_sh_hi;
      r_sh_lo   <= w_sh_lo;
      r_sh_win  <= w_sh_win;
      r_sh_cont <= w_sh_cont;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state      <= ST_IDLE;
      r_last       <= LV_NONE;
      r_settle     <= '0;
      r_win        <= '0;
      r_w_hi       <= '0;
      r_w_lo       <= '0;
      r_w_z        <= '0;
      r_w_rise     <= '0;
      r_stop       <= 1'b0;
      dac1_code    <= '0;
      dac2_code    <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      cnt_high     <= '0;
      cnt_low      <= '0;
      cnt_z        <= '0;
      cnt_rise     <= '0;
    end else begin
      result_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_stop <= 1'b0;
          if (cfg_write) begin
            dac1_code <= w_sh_hi;
            dac2_code <= w_sh_lo;
          end
        end
        ST_SETTLE: begin
          if (stop) r_stop <= 1'b1;
          if (r_settle == '0) r_state <= ST_MEASURE;
          else r_settle <= r_settle - 1'b1;
        end
        ST_MEASURE: begin
          if (stop) r_stop <= 1'b1;
          r_w_hi   <= w_n_hi;
          r_w_lo   <= w_n_lo;
          r_w_z    <= w_n_z;
          r_w_rise <= w_n_rise;
          r_last   <= w_n_last;
          r_win    <= r_win - 1'b1;
          if (r_win == '0) begin
            r_state      <= ST_DONE;
            result_valid <= 1'b1;
            cnt_high     <= w_n_hi;
            cnt_low      <= w_n_lo;
            cnt_z        <= w_n_z;
            cnt_rise     <= w_n_rise;
          end
        end
        ST_DONE: begin
          if (!w_enter) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
            r_stop  <= 1'b0;
          end
        end
      endcase
      if (w_enter) begin
        r_state   <= ST_SETTLE;
        busy      <= 1'b1;
        dac1_code <= w_sh_hi;
        dac2_code <= w_sh_lo;
        r_settle  <= SETTLE_INIT;
        r_win     <= w_sh_win - 1'b1;
        r_w_hi    <= '0;
        r_w_lo    <= '0;
        r_w_z     <= '0;
        r_w_rise  <= '0;
        r_last    <= LV_NONE;
      end
    end
  end

endmodule

// File: tb/tb_probe_level_ctrl.sv
// Randomized bench for probe_level_ctrl against a cycle-indexed
// event model built from the comparator input history.
module tb_probe_level_ctrl;

  localparam int CB = 20;
  localparam int ST = 16;
  localparam int HN = 16384;

  logic          clk = 1'b0;
  logic          nreset;
  logic [4:0]    cfg_hi_code;
  logic [4:0]    cfg_lo_code;
  logic [CB-1:0] cfg_window;
  logic          cfg_continuous;
  logic          cfg_write;
  logic          start;
  logic          stop;
  logic          comp_out_hi;
  logic          comp_out_lo;
  logic [4:0]    dac1_code;
  logic [4:0]    dac2_code;
  logic          busy;
  logic          result_valid;
  logic [CB-1:0] cnt_high;
  logic [CB-1:0] cnt_low;
  logic [CB-1:0] cnt_z;
  logic [CB-1:0] cnt_rise;

  always #5 clk = ~clk;

  probe_level_ctrl #(.COUNT_BITS(CB), .SETTLE_CYCLES(ST)) dut (
    .clk            (clk),
    .nreset         (nreset),
    .cfg_hi_code    (cfg_hi_code),
    .cfg_lo_code    (cfg_lo_code),
    .cfg_window     (cfg_window),
    .cfg_continuous (cfg_continuous),
    .cfg_write      (cfg_write),
    .start          (start),
    .stop           (stop),
    .comp_out_hi    (comp_out_hi),
    .comp_out_lo    (comp_out_lo),
    .dac1_code      (dac1_code),
    .dac2_code      (dac2_code),
    .busy           (busy),
    .result_valid   (result_valid),
    .cnt_high       (cnt_high),
    .cnt_low        (cnt_low),
    .cnt_z          (cnt_z),
    .cnt_rise       (cnt_rise)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // history of {hi,lo} comparator inputs seen at each edge
  bit [1:0] hist [HN];
  int cyc = 0;
  int mode = 0;
  int pat_base = 0;
  int rv_edges[$];

  bit m_busy, m_rv, m_pend, m_stop, sh_cont;
  int m_S, m_W, sh_hi, sh_lo, sh_win, m_d1, m_d2;
  int m_c[4];

  function automatic void model_reset();
    m_busy = 0; m_rv = 0; m_pend = 0; m_stop = 0;
    sh_hi = 0; sh_lo = 0; sh_win = 1; sh_cont = 0;
    m_d1 = 0; m_d2 = 0;
    for (int i = 0; i < 4; i++) m_c[i] = 0;
  endfunction

  // samples at measure edges lag the pins by two synchronizer edges
  function automatic void model_result();
    int last;
    bit h, l;
    last = 0;
    for (int i = 0; i < 4; i++) m_c[i] = 0;
    for (int k = m_S + ST - 1; k <= m_S + ST + m_W - 2; k++) begin
      {h, l} = hist[k % HN];
      if (h) begin
        m_c[0]++;
        if (last == 1) m_c[3]++;
        last = 2;
      end else if (l) begin
        m_c[1]++;
        last = 1;
      end else begin
        m_c[2]++;
      end
    end
  endfunction

  task automatic tick();
    int e, ph, nhi, nlo, nwin;
    bit h, l, ncont, go_on;
    case (mode)
      0: begin
        h = 1'($urandom_range(0, 1));
        l = 1'($urandom_range(0, 1));
      end
      1: begin
        ph = ((cyc - pat_base) % 10 + 10) % 10;
        h = (ph >= 6);
        l = (ph < 4);
      end
      2: begin h = 1; l = 0; end
      default: begin h = 1; l = 1; end
    endcase
    comp_out_hi = h;
    comp_out_lo = l;
    hist[cyc % HN] = {h, l};
    @(posedge clk);
    e = cyc;
    cyc++;
    nhi   = cfg_write ? int'(cfg_hi_code) : sh_hi;
    nlo   = cfg_write ? int'(cfg_lo_code) : sh_lo;
    ncont = cfg_write ? cfg_continuous : sh_cont;
    nwin  = !cfg_write ? sh_win :
            (cfg_window == 0) ? 1 : int'(cfg_window);
    m_rv = 0;
    go_on = 0;
    if (!nreset) begin
      model_reset();
    end else begin
      if (!m_busy) begin
        if (start) go_on = 1;
        else if (cfg_write) begin m_d1 = nhi; m_d2 = nlo; end
      end else if (m_pend) begin
        m_pend = 0;
        if (ncont && !(m_stop || stop)) go_on = 1;
        else begin m_busy = 0; m_stop = 0; end
      end else begin
        if (stop) m_stop = 1;
        if (e == m_S + ST + m_W) begin
          model_result();
          m_rv = 1;
          m_pend = 1;
          rv_edges.push_back(e);
        end
      end
      if (go_on) begin
        m_busy = 1; m_stop = 0;
        m_S = e; m_W = nwin;
        m_d1 = nhi; m_d2 = nlo;
      end
      sh_hi = nhi; sh_lo = nlo; sh_win = nwin; sh_cont = ncont;
    end
    #1;
    chk("rv", result_valid, m_rv);
    chk("busy", busy, m_busy);
    chk("dac1", dac1_code, m_d1);
    chk("dac2", dac2_code, m_d2);
    chk("cnt_high", cnt_high, m_c[0]);
    chk("cnt_low", cnt_low, m_c[1]);
    chk("cnt_z", cnt_z, m_c[2]);
    chk("cnt_rise", cnt_rise, m_c[3]);
    start = 0;
    stop = 0;
    cfg_write = 0;
  endtask

  task automatic cfgw(input int hi, input int lo, input int win,
                      input bit cont, input bit st);
    cfg_hi_code    = 5'(hi);
    cfg_lo_code    = 5'(lo);
    cfg_window     = CB'(win);
    cfg_continuous = cont;
    cfg_write      = 1;
    start          = st;
    if (st) pat_base = cyc + ST - 1;
    tick();
  endtask

  task automatic go();
    start = 1;
    pat_base = cyc + ST - 1;
    tick();
  endtask

  task automatic wait_rv(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!result_valid && n < budget);
    if (!result_valid) chk("rv_timeout", result_valid, 1);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_rv"}, result_valid, 0);
    chk({pfx, "_dac1"}, dac1_code, 0);
    chk({pfx, "_dac2"}, dac2_code, 0);
    chk({pfx, "_hi"}, cnt_high, 0);
    chk({pfx, "_lo"}, cnt_low, 0);
    chk({pfx, "_z"}, cnt_z, 0);
    chk({pfx, "_rise"}, cnt_rise, 0);
  endtask

  initial begin
    int n, w, b;
    nreset = 0;
    cfg_hi_code = 0; cfg_lo_code = 0; cfg_window = 0;
    cfg_continuous = 0; cfg_write = 0;
    start = 0; stop = 0;
    comp_out_hi = 0; comp_out_lo = 0;
    model_reset();
    tick();
    tick();
    chk_zero("rst");
    nreset = 1;
    tick();
    cfgw(20, 6, 100, 0, 0);
    chk("cfg_dac1", dac1_code, 20);
    chk("cfg_dac2", dac2_code, 6);
    chk("cfg_busy", busy, 0);

    mode = 2;
    go();
    wait_rv(300, n);
    chk("lat_single", n + 1, 1 + ST + 100);
    chk("single_hi", cnt_high, 100);
    chk("single_lo", cnt_low, 0);
    chk("single_z", cnt_z, 0);
    chk("single_rise", cnt_rise, 0);
    tick();
    chk("busy_fall", busy, 0);

    mode = 1;
    cfgw(20, 6, 100, 0, 1);
    wait_rv(300, n);
    chk("pat_lo", cnt_low, 40);
    chk("pat_z", cnt_z, 20);
    chk("pat_hi", cnt_high, 40);
    chk("pat_rise", cnt_rise, 10);
    tick();

    mode = 3;
    cfgw(20, 6, 3, 0, 1);
    wait_rv(100, n);
    chk("both_hi", cnt_high, 3);
    tick();

    mode = 0;
    b = rv_edges.size();
    cfgw(20, 6, 10, 1, 1);
    wait_rv(100, n);
    chk("lat_cont", n + 1, 1 + ST + 10);
    repeat (5) tick();
    cfgw(31, 6, 10, 1, 0);
    wait_rv(100, n);
    chk("dac1_hold", dac1_code, 20);
    chk("gap1", rv_edges[b + 1] - rv_edges[b], 1 + ST + 10);
    tick();
    chk("dac1_new", dac1_code, 31);
    repeat (5) tick();
    stop = 1;
    tick();
    wait_rv(100, n);
    chk("gap2", rv_edges[b + 2] - rv_edges[b + 1], 1 + ST + 10);
    tick();
    chk("stop_idle", busy, 0);
    repeat (30) tick();
    chk("cont_count", rv_edges.size() - b, 3);

    cfgw(5, 3, 0, 0, 0);
    go();
    repeat (3) tick();
    go();
    wait_rv(100, n);
    chk("lat_w0", n + 5, 1 + ST + 1);
    chk("sum_w0", cnt_high + cnt_low + cnt_z, 1);
    tick();
    stop = 1;
    tick();
    chk("stop_in_idle", busy, 0);

    for (int t = 0; t < 4; t++) begin
      w = $urandom_range(1, 40);
      mode = $urandom_range(0, 3);
      cfgw($urandom_range(0, 31), $urandom_range(0, 31), w, 0, 1);
      wait_rv(200, n);
      chk("rnd_lat", n + 1, 1 + ST + w);
      chk("rnd_sum", cnt_high + cnt_low + cnt_z, w);
      tick();
    end

    mode = 0;
    b = rv_edges.size();
    cfgw(9, 9, 50, 0, 1);
    repeat (30) tick();
    #2;
    nreset = 0;
    #1;
    chk_zero("arst");
    tick();
    tick();
    nreset = 1;
    chk("arst_no_rv", rv_edges.size() - b, 0);
    repeat (3) tick();
    cfgw(4, 2, 5, 0, 1);
    wait_rv(100, n);
    chk("post_rst_lat", n + 1, 1 + ST + 5);
    chk("post_rst_sum", cnt_high + cnt_low + cnt_z, 5);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/probe_level_ctrl.md
Name: probe_level_ctrl

Overview:
- Sequences the logic probe's two threshold DACs and measures the comparator outputs over a programmable window.
- Sits between the CPU register interface and the dac1_code/dac2_code/comp_out_hi/comp_out_lo pins of the logic probe top level.
- Applies the threshold codes, waits for the analog front end to settle, then classifies every sample as high, low or Z and counts rising edges.
- Reports the counts to the CPU with a one-cycle valid pulse; supports single-shot and continuous operation.

Parameters:
- COUNT_BITS, 20, width of the window length and of every result counter.
- SETTLE_CYCLES, 16, clock cycles waited after the DAC codes are applied, before measuring (legal range 1..255).

Ports:
- clk  input  1  system clock
- nreset  input  1  asynchronous active-low reset
- cfg_hi_code  input  5  high-threshold DAC code
- cfg_lo_code  input  5  low-threshold DAC code
- cfg_window  input  COUNT_BITS  measurement window length in cycles
- cfg_continuous  input  1  1 = restart automatically after each result
- cfg_write  input  1  one-cycle strobe; captures cfg_* into shadow registers
- start  input  1  one-cycle strobe; begins a measurement
- stop  input  1  one-cycle strobe; ends continuous mode after the current window
- comp_out_hi  input  1  asynchronous; 1 = probe input above the high threshold
- comp_out_lo  input  1  asynchronous; 1 = probe input below the low threshold
- dac1_code  output  5  high-threshold DAC drive
- dac2_code  output  5  low-threshold DAC drive
- busy  output  1  1 while not in IDLE
- result_valid  output  1  one-cycle pulse; results updated
- cnt_high  output  COUNT_BITS  samples classified high
- cnt_low  output  COUNT_BITS  samples classified low
- cnt_z  output  COUNT_BITS  samples classified Z
- cnt_rise  output  COUNT_BITS  low-to-high transitions

Behaviour:
- Reset (async, nreset=0):
  - State IDLE.
  - All outputs 0.
  - Shadow hi/lo codes 0, window 1, continuous 0.
  - Synchronizer flops 0; last-definite-level register = NONE.
- Comparator inputs: each passes through a 2-flop synchronizer. All classification uses the synced values.
- Sample classification:
  - hi_s=1 -> HIGH. This takes priority when both synced comparators are 1.
  - Else lo_s=1 -> LOW.
  - Else Z.
- cfg_write:
  - Accepted in any state; shadow registers update on the next edge.
  - Window value 0 is stored as 1.
  - In IDLE, dac1_code/dac2_code follow the shadow codes one cycle after cfg_write.
  - While busy, the DAC outputs do not change until the next SETTLE entry.
  - cfg_write and start in the same cycle: start uses the newly written values.
- States:
  - IDLE:
    - start=1 -> SETTLE.
    - On entry to SETTLE: dac1_code<=shadow hi, dac2_code<=shadow lo, settle counter<=SETTLE_CYCLES-1, window counter<=shadow window-1, all work counters cleared, last level NONE.
  - SETTLE:
    - Decrements each cycle; at 0 -> MEASURE. Exactly SETTLE_CYCLES cycles are spent in SETTLE.
    - Samples are not counted.
  - MEASURE:
    - Each cycle, one sample is classified and its counter increments.
    - cnt_rise increments when the sample is HIGH and the last definite level is LOW. Z samples do not change the last definite level, so LOW-Z-HIGH counts as one rise.
    - The window counter decrements; when it is 0 that cycle's sample is included -> DONE. Exactly window samples are counted.
  - DONE (1 cycle):
    - Work counters copy into cnt_* outputs; result_valid=1.
    - If continuous and no stop was latched -> SETTLE, with a fresh shadow read.
    - Otherwise -> IDLE.
- Counters saturate at all-ones. Saturation is reachable only in cnt_rise's sibling paths if COUNT_BITS is overridden; the required behaviour is hold, never wrap.
- Invariant: cnt_high+cnt_low+cnt_z = window for every result.
- start while busy: ignored.
- stop:
  - Latched while busy; cleared on IDLE entry.
  - stop in IDLE: ignored.
  - The stop latch affects only the DONE decision. The current window always completes.
- cnt_* outputs hold their last result until the next DONE. They are not cleared by start.
- busy=1 from the cycle after start through DONE; it is 0 in the cycle following the final DONE.
- Reset mid-operation: immediate return to the reset values; result_valid is never asserted for the aborted window.

Test Plan:
- Reset then idle: all outputs 0. cfg_write hi=20 lo=6 -> dac1_code=20, dac2_code=6 the next cycle; busy stays 0.
- Single shot, SETTLE_CYCLES=16, window=100, comp_out_hi held 1, comp_out_lo held 0 -> result_valid after 1+16+100 cycles. Results: cnt_high=100, cnt_low=0, cnt_z=0, cnt_rise=0. busy then falls.
- Toggle the comparators through the cycle low(4), Z(2), high(4), repeating over window=100 -> cnt_low=40, cnt_z=20, cnt_high=40, cnt_rise=10 (exact once synchronizer latency is aligned). Both comparators high for one sample -> counted high.
- Continuous mode, window=10:
  - Three consecutive result_valid pulses spaced 1+16+10 cycles apart.
  - cfg_write hi=31 during the second window -> dac1_code changes only at the third SETTLE entry.
  - stop during the third window -> IDLE after the third result.
- start while busy and window=0: the extra start is ignored; window=0 gives a 1-sample result with sum=1.
- nreset asserted mid-MEASURE -> all outputs 0 asynchronously, no result_valid. Restart with window=5 gives correct counts.
